// File: rtl/inst_prefetch.sv
// -----------------------------------------------------------------------------
// inst_prefetch
//   Instruction prefetcher. It streams sequential instruction words from an
//   in-order ROM into a small queue and presents the head instruction with its
//   byte address. A redirect flushes the queue and restarts fetching at a new
//   address. Responses still in flight from before the redirect are counted and
//   discarded when they return.
//
// Parameters
//   DEPTH     queue depth in words (power of 2, >= 2); also the request credit
//   RESET_PC  first fetch byte address after reset
//
// Ports
//   clk             clock, rising edge
//   i_reset         asynchronous active-low reset
//   i_redirect      flush-and-refetch strobe
//   i_redirect_pc   new fetch byte address (low two bits ignored)
//   i_deq           consumer takes the head instruction
//   o_valid         head instruction valid
//   o_instruction   head instruction word
//   o_pc            byte address of the head instruction
//   o_mem_req       ROM fetch request
//   o_mem_addr      ROM byte address, word aligned
//   i_mem_gnt       ROM accepts the request this cycle
//   i_mem_rvalid    ROM read data valid (in order, >= 1 cycle after grant)
//   i_mem_rdata     ROM read data
//
// Handshakes
//   ROM request : a request transfers on a rising edge where o_mem_req and
//                 i_mem_gnt are both 1. While o_mem_req=1 and i_mem_gnt=0 the
//                 address is held. o_mem_req does not depend on i_mem_gnt.
//   ROM response: every i_mem_rvalid cycle returns exactly one earlier grant,
//                 in grant order. There is no back-pressure on responses; the
//                 credit rule guarantees a free queue slot for each of them.
//   Consumer    : the head transfers on a rising edge where o_valid and i_deq
//                 are both 1. i_deq while o_valid=0 has no effect.
// -----------------------------------------------------------------------------
module inst_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_deq,
  output logic        o_valid,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata
);

  localparam int AW = $clog2(DEPTH);
  // Counters hold 0..DEPTH inclusive, so they need one bit more than a pointer.
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Fetch state
  logic [31:0]   r_fpc;
  logic [31:0]   r_out_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outstanding;
  logic [CW-1:0] r_drop;

  // Queue storage
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [DEPTH];

  logic          w_credit;
  logic          w_grant;
  logic          w_drop_hit;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_inflight_next;
  logic [31:0]   w_redirect_pc;

  // A request is only made when every outstanding response already has a
  // reserved queue slot, so a returning response can never find the queue full.
  assign w_credit   = (r_count + r_outstanding) < DEPTH_C;
  // Gated with reset so no request is seen while the block is held in reset.
  assign o_mem_req  = i_reset & w_credit;
  assign o_mem_addr = {r_fpc[31:2], 2'b00};

  assign w_grant    = o_mem_req & i_mem_gnt;
  assign w_drop_hit = i_mem_rvalid & (r_drop != '0);
  // A response arriving in a redirect cycle belongs to the old stream.
  assign w_push     = i_mem_rvalid & ~w_drop_hit & ~i_redirect;
  assign w_pop      = i_deq & o_valid & ~i_redirect;

  // In-flight count after this edge. On a redirect every one of these
  // responses is stale, which is exactly the number to drop.
  assign w_inflight_next = r_outstanding + CW'(w_grant) - CW'(i_mem_rvalid);

  assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

  assign o_valid       = (r_count != '0);
  assign o_instruction = r_mem[r_rd_ptr];
  assign o_pc          = r_out_pc;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_fpc         <= RESET_PC;
      r_out_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else begin
      r_outstanding <= w_inflight_next;
      if (i_redirect) begin
        // The redirect target wins over any fpc advance from a same-cycle
        // grant; that grant is still counted in w_inflight_next and dropped.
        r_fpc    <= w_redirect_pc;
        r_out_pc <= w_redirect_pc;
        r_count  <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_drop   <= w_inflight_next;
      end else begin
        if (w_grant) begin
          r_fpc <= r_fpc + 32'd4;
        end
        if (w_pop) begin
          r_out_pc <= r_out_pc + 32'd4;
          r_rd_ptr <= r_rd_ptr + AW'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + AW'(1);
        end
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
        if (w_drop_hit) begin
          r_drop <= r_drop - CW'(1);
        end
      end
    end
  end

  // Queue storage carries no reset; entries are only read when r_count says so.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_mem_rdata;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk) disable iff (!i_reset)
    !(w_push && !w_pop && (r_count == DEPTH_C)))
    else $error("instruction queue overflow");

  a_drop_bounded: assert property (@(posedge clk) disable iff (!i_reset)
    r_drop <= r_outstanding)
    else $error("drop count exceeds outstanding");

  a_rvalid_expected: assert property (@(posedge clk) disable iff (!i_reset)
    !(i_mem_rvalid && (r_outstanding == '0)))
    else $error("response with nothing outstanding");

  a_addr_hold: assert property (@(posedge clk) disable iff (!i_reset)
    (o_mem_req && !i_mem_gnt && !i_redirect) |=> (o_mem_addr == $past(o_mem_addr)))
    else $error("request address changed while waiting for grant");
`endif

endmodule

// File: tb/tb_inst_prefetch.sv
// -----------------------------------------------------------------------------
// tb_inst_prefetch
//   Bench for inst_prefetch. A ROM model answers grants in order with a
//   configurable latency. The reference model tracks the expected head of the
//   instruction stream as a queue of words plus the fetch and output addresses;
//   in-flight ROM requests are tagged stale when a redirect overtakes them.
// -----------------------------------------------------------------------------
module tb_inst_prefetch;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RP    = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_deq;
  logic        o_valid;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;

  inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(RP)) dut (
    .clk           (clk),
    .i_reset       (i_reset),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .i_deq         (i_deq),
    .o_valid       (o_valid),
    .o_instruction (o_instruction),
    .o_pc          (o_pc),
    .o_mem_req     (o_mem_req),
    .o_mem_addr    (o_mem_addr),
    .i_mem_gnt     (i_mem_gnt),
    .i_mem_rvalid  (i_mem_rvalid),
    .i_mem_rdata   (i_mem_rdata)
  );

  // ---------------- model state ----------------
  typedef struct {
    logic [31:0] addr;   // address the ROM was asked for
    logic [31:0] expd;   // word the model expects for this fetch
    int          due;    // first step at which the ROM may answer
    bit          stale;  // overtaken by a redirect
  } req_t;

  req_t        rom_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_fpc;
  logic [31:0] m_out_pc;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;
  int g_cnt = 0;
  bit last_hit;

  int          p_gnt, p_deq, p_redir, p_rv, lat_lo, lat_hi;
  bit          f_redir = 1'b0;
  logic [31:0] f_pc;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic bit roll(input int p);
    return int'($urandom_range(99)) < p;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic exp_req;
    exp_req = i_reset && ((exp_q.size() + rom_q.size()) < DEPTH);
    chk("valid", {31'b0, o_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) chk("instr", o_instruction, exp_q[0]);
    chk("pc", o_pc, m_out_pc);
    chk("req", {31'b0, o_mem_req}, {31'b0, exp_req});
    if (exp_req) chk("addr", o_mem_addr, m_fpc);
  endtask

  // ---------------- driver ----------------
  task automatic set_knobs(input int g, input int d, input int r, input int v,
                           input int lo, input int hi);
    p_gnt = g; p_deq = d; p_redir = r; p_rv = v; lat_lo = lo; lat_hi = hi;
  endtask

  // One cycle: check the outputs at the falling edge, then drive the inputs
  // for the next rising edge and advance the model by that edge.
  task automatic step();
    bit          grant;
    bit          rv;
    logic [31:0] tgt;
    req_t        e;
    @(negedge clk);
    cyc++;
    check_outputs();
    last_hit = 1'b0;
    if (!i_reset) begin
      f_redir = 1'b0;
      return;
    end
    i_mem_gnt     = roll(p_gnt);
    i_deq         = roll(p_deq);
    i_redirect    = f_redir || roll(p_redir);
    if (f_redir)      tgt = f_pc;
    else if (roll(20)) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15));
    else              tgt = $urandom;
    i_redirect_pc = tgt;
    f_redir       = 1'b0;

    rv = (rom_q.size() != 0) && (rom_q[0].due <= cyc) && roll(p_rv);
    i_mem_rvalid = rv;
    i_mem_rdata  = rv ? rom_word(rom_q[0].addr) : $urandom;

    grant = o_mem_req && i_mem_gnt;
    if (grant) g_cnt++;
    last_hit = i_redirect && grant && rv;

    // consumer side sees the queue as it was before this edge
    if (i_deq && (exp_q.size() != 0) && !i_redirect) begin
      void'(exp_q.pop_front());
      m_out_pc = m_out_pc + 32'd4;
    end
    if (rv) begin
      e = rom_q.pop_front();
      if (!e.stale && !i_redirect) exp_q.push_back(e.expd);
    end
    if (grant) begin
      e.addr  = o_mem_addr;
      e.expd  = rom_word(m_fpc);
      e.due   = cyc + int'($urandom_range(lat_hi, lat_lo));
      e.stale = 1'b0;
      rom_q.push_back(e);
      m_fpc = m_fpc + 32'd4;
    end
    if (i_redirect) begin
      foreach (rom_q[i]) rom_q[i].stale = 1'b1;
      exp_q.delete();
      m_fpc    = {tgt[31:2], 2'b00};
      m_out_pc = {tgt[31:2], 2'b00};
    end
  endtask

  // The ROM is reset together with the block, so its queue is emptied too.
  task automatic do_reset();
    i_reset       = 1'b0;
    i_redirect    = 1'b0;
    i_redirect_pc = '0;
    i_deq         = 1'b0;
    i_mem_gnt     = 1'b0;
    i_mem_rvalid  = 1'b0;
    i_mem_rdata   = '0;
    rom_q.delete();
    exp_q.delete();
    m_fpc    = RP;
    m_out_pc = RP;
    repeat (3) step();
    i_reset = 1'b1;
  endtask

  task automatic deq_once();
    int save;
    save  = p_deq;
    p_deq = 100;
    step();
    p_deq = save;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // sequential stream, 1-cycle ROM, always granted, always consumed
    set_knobs(100, 100, 0, 100, 1, 1);
    do_reset();
    repeat (30) step();

    // redirect while a grant and a response share the cycle
    f_redir = 1'b1;
    f_pc    = 32'h0000_2000;
    step();
    chk("r36_cond", {31'b0, last_hit}, 32'd1);
    p_deq = 0;
    repeat (6) step();
    chk("r36_pc", o_pc, 32'h0000_2000);
    chk("r36_ins", o_instruction, rom_word(32'h0000_2000));

    // address wrap
    f_redir = 1'b1;
    f_pc    = 32'hFFFF_FFF8;
    step();
    repeat (6) step();
    chk("r37_pc0", o_pc, 32'hFFFF_FFF8);
    deq_once();
    chk("r37_pc1", o_pc, 32'hFFFF_FFFC);
    deq_once();
    chk("r37_pc2", o_pc, 32'h0000_0000);
    chk("r37_ins", o_instruction, rom_word(32'h0000_0000));

    // credit limit with no consumer
    do_reset();
    g_cnt = 0;
    repeat (10) step();
    chk("r34_grants", g_cnt, 32'd4);
    chk("r34_req", {31'b0, o_mem_req}, 32'd0);
    chk("r34_valid", {31'b0, o_valid}, 32'd1);
    deq_once();
    repeat (6) step();
    chk("r34_grants1", g_cnt, 32'd5);

    // 3-cycle ROM, redirect with three responses in flight
    set_knobs(100, 0, 0, 100, 3, 3);
    do_reset();
    step();
    step();
    f_redir = 1'b1;
    f_pc    = 32'h0000_0102;
    step();
    repeat (12) step();
    chk("r35_pc", o_pc, 32'h0000_0100);
    chk("r35_ins", o_instruction, rom_word(32'h0000_0100));

    // grant withheld: address holds, then advances by one word
    set_knobs(0, 100, 0, 100, 1, 1);
    do_reset();
    g_cnt = 0;
    repeat (5) begin
      step();
      chk("r38_hold", o_mem_addr, RP);
    end
    p_gnt = 100;
    step();
    p_gnt = 0;
    step();
    chk("r38_adv", o_mem_addr, RP + 32'd4);
    chk("r38_grants", g_cnt, 32'd1);

    // random traffic with mid-run resets between segments
    for (int k = 0; k < 4; k++) begin
      set_knobs(70, 60, 4, 70, 1, 4);
      do_reset();
      repeat (1500) step();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
